button_event_arb: RTL
=====================

BUTTON_EVENT_ARB -- requirements
Module: button_event_arb

Interface
REQ-001 The block SHALL have parameter NB_BUTTONS, default 4, giving the number of button inputs (1..16).
REQ-002 The block SHALL have parameter CLK_FREQ_KHZ, default 95000, giving the clock frequency in kHz and the cycles per 1 ms tick.
REQ-003 The block SHALL have parameter DEBOUNCE_MS, default 20, giving the stable time in ticks needed before a debounced state change (>=1).
REQ-004 The block SHALL have parameter LONG_PRESS_MS, default 1000, giving the hold time in ticks before a long-press event (>DEBOUNCE_MS).
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, giving the event FIFO depth (power of 2, >=2).
REQ-006 clk  input  1  clock; all state is updated on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 btn_in  input  NB_BUTTONS  raw asynchronous button levels, 1 = pressed.
REQ-009 btn_state  output  NB_BUTTONS  debounced button levels.
REQ-010 evt_valid  output  1  an event is present at the FIFO head.
REQ-011 evt_ready  input  1  the consumer accepts the head event.
REQ-012 evt_data  output  2+IW  {type[1:0], index[IW-1:0]}, where IW = max(1, clog2(NB_BUTTONS)).
REQ-013 evt_ovf  output  1  sticky flag: one or more events were lost.
REQ-014 ovf_clr  input  1  clears evt_ovf.

Function
REQ-015 A prescaler SHALL count 0..CLK_FREQ_KHZ-1 and assert the internal tick for exactly one cycle each time it wraps.
REQ-016 Each btn_in bit SHALL pass through a 2-flop synchronizer before any use.
REQ-017 Each button's stable counter SHALL clear on any cycle where the synchronized input equals btn_state, and SHALL increment on each tick otherwise.
REQ-018 When the stable counter reaches DEBOUNCE_MS, the block SHALL on the next edge invert btn_state, clear the counter, and set the pending flag PRESS (code 01) for a 0->1 transition or RELEASE (code 10) for a 1->0 transition.
REQ-019 A pulse shorter than DEBOUNCE_MS ticks SHALL cause no state change and no event.
REQ-020 A per-button hold counter SHALL clear while btn_state=0 and increment on each tick while btn_state=1, saturating at LONG_PRESS_MS.
REQ-021 The block SHALL set pending flag LONG (code 11) exactly once per press, on the cycle the hold counter first reaches LONG_PRESS_MS.
REQ-022 Setting a pending flag that is already set and is not being granted in the same cycle SHALL set evt_ovf; the earlier event is kept.
REQ-023 In each cycle where FIFO occupancy (registered) < FIFO_DEPTH, the arbiter SHALL grant one button: the first button with any pending flag, searching upward from the round-robin pointer with wrap-around.
REQ-024 Within the granted button, flag priority SHALL be PRESS > LONG > RELEASE; only that flag is cleared and only that event is written.
REQ-025 After each grant, the pointer SHALL become (granted index + 1) mod NB_BUTTONS; with no grant, it SHALL hold.
REQ-026 If a flag is granted and set again in the same cycle, the flag SHALL remain set and evt_ovf SHALL NOT be set.
REQ-027 The FIFO full condition SHALL block grants; pending flags SHALL hold until space frees, so no event is dropped due to FIFO full.
REQ-028 evt_valid SHALL equal (occupancy != 0); evt_data SHALL show the head entry; a transfer occurs on a cycle with evt_valid & evt_ready.
REQ-029 A simultaneous write and read SHALL leave occupancy unchanged, and events SHALL leave the FIFO in write order.
REQ-030 Latency SHALL be as follows: pending flag set at edge T, written at edge T+1 if not blocked, evt_valid high after edge T+1 with an empty FIFO.
REQ-031 ovf_clr SHALL clear evt_ovf unless a new overflow occurs in the same cycle, in which case set wins.

Reset
REQ-032 While rst=1, the block SHALL clear the prescaler, synchronizers, counters, pending flags, pointer, FIFO pointers, and occupancy.
REQ-033 While rst=1, the outputs SHALL be btn_state=0, evt_valid=0, evt_data=0, evt_ovf=0.
REQ-034 A reset asserted mid-operation SHALL discard all queued and pending events.
REQ-035 A button held during reset release SHALL produce PRESS after DEBOUNCE_MS ticks.

Verification (CLK_FREQ_KHZ=10, DEBOUNCE_MS=3, LONG_PRESS_MS=8, NB_BUTTONS=4, FIFO_DEPTH=4)
REQ-036 Scenario: btn_in[2] high for 2 ticks then low -> no event, btn_state stays 0.
REQ-037 Scenario: btn_in[1] held 10 ticks then released >=3 ticks, evt_ready=1 -> events in order 01/1, 11/1, 10/1, with each evt_valid one cycle wide.
REQ-038 Scenario: buttons 0..3 pressed on the same cycle, evt_ready=1 -> PRESS events for indices 0,1,2,3 on consecutive cycles.
REQ-039 Scenario: evt_ready=0, five presses/releases generated -> 4 entries queued, fifth held pending (evt_ovf=0); one read -> fifth enters the FIFO.
REQ-040 Scenario: evt_ready=0, FIFO full, button 0 presses and releases, then presses again before its PRESS drains -> evt_ovf=1; ovf_clr pulse -> evt_ovf=0.
REQ-041 Scenario: rst pulsed with 3 events queued -> evt_valid=0 the same cycle and no stale events after release.

Source files
------------

// File: rtl/button_event_arb.sv
// Debounced button scanner that turns press, long-press and release transitions into
// events, arbitrated round-robin across buttons into a small FIFO with overflow flag.
module button_event_arb #(
    parameter int NB_BUTTONS    = 4,
    parameter int CLK_FREQ_KHZ  = 95000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int FIFO_DEPTH    = 4,
    localparam int IW = (NB_BUTTONS > 1) ? $clog2(NB_BUTTONS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_BUTTONS-1:0] btn_in,
    output logic [NB_BUTTONS-1:0] btn_state,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IW+1:0]         evt_data,
    output logic                  evt_ovf,
    input  logic                  ovf_clr
);

    localparam int PW = $clog2(CLK_FREQ_KHZ + 1);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int LW = $clog2(LONG_PRESS_MS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_LONG    = 2'b11
    } evt_type_t;

    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % NB_BUTTONS;
    endfunction

    logic [PW-1:0]         pre_cnt;
    logic                  tick;
    logic [NB_BUTTONS-1:0] sync_q1, sync_q2;
    logic [DW-1:0]         stab_cnt [NB_BUTTONS];
    logic [LW-1:0]         hold_cnt [NB_BUTTONS];
    logic [NB_BUTTONS-1:0] toggle, set_press, set_rel, set_long;
    logic [NB_BUTTONS-1:0] pend_press, pend_rel, pend_long, pend_any;
    logic [NB_BUTTONS-1:0] clr_press, clr_rel, clr_long;
    logic                  ovf_hit;
    logic [IW-1:0]         rr_ptr;
    logic                  gnt_valid;
    logic [IW-1:0]         gnt_idx;
    evt_type_t             gnt_type;
    logic [IW+1:0]         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic                  do_wr, do_rd;

    // 1 ms time base shared by every per-button counter
    assign tick = (pre_cnt == PW'(CLK_FREQ_KHZ - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        for (int i = 0; i < NB_BUTTONS; i++) begin
            toggle[i]   = (sync_q2[i] != btn_state[i]) && (stab_cnt[i] == DW'(DEBOUNCE_MS));
            set_long[i] = btn_state[i] && tick && (hold_cnt[i] == LW'(LONG_PRESS_MS - 1));
        end
    end

    assign set_press = toggle & ~btn_state;
    assign set_rel   = toggle & btn_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_state <= '0;
            for (int i = 0; i < NB_BUTTONS; i++) begin
                stab_cnt[i] <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_BUTTONS; i++) begin
                if (sync_q2[i] == btn_state[i]) begin
                    stab_cnt[i] <= '0;
                end else if (toggle[i]) begin
                    stab_cnt[i]  <= '0;
                    btn_state[i] <= ~btn_state[i];
                end else if (tick) begin
                    stab_cnt[i] <= stab_cnt[i] + DW'(1);
                end

                if (!btn_state[i]) begin
                    hold_cnt[i] <= '0;
                end else if (tick && hold_cnt[i] != LW'(LONG_PRESS_MS)) begin
                    hold_cnt[i] <= hold_cnt[i] + LW'(1);
                end
            end
        end
    end

    assign pend_any = pend_press | pend_long | pend_rel;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (fifo_cnt < CW'(FIFO_DEPTH)) begin
            for (int k = 0; k < NB_BUTTONS; k++) begin
                if (!gnt_valid && pend_any[wrap_idx(int'(rr_ptr), k)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IW'(wrap_idx(int'(rr_ptr), k));
                end
            end
        end
    end

    always_comb begin
        clr_press = '0;
        clr_long  = '0;
        clr_rel   = '0;
        gnt_type  = EVT_NONE;
        if (gnt_valid) begin
            if (pend_press[gnt_idx]) begin
                clr_press[gnt_idx] = 1'b1;
                gnt_type           = EVT_PRESS;
            end else if (pend_long[gnt_idx]) begin
                clr_long[gnt_idx] = 1'b1;
                gnt_type          = EVT_LONG;
            end else begin
                clr_rel[gnt_idx] = 1'b1;
                gnt_type         = EVT_RELEASE;
            end
        end
    end

    // A re-set of a flag that is being granted this cycle is a fresh event, not a loss
    assign ovf_hit = |((set_press & pend_press & ~clr_press) |
                       (set_long  & pend_long  & ~clr_long)  |
                       (set_rel   & pend_rel   & ~clr_rel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_press <= '0;
            pend_long  <= '0;
            pend_rel   <= '0;
            rr_ptr     <= '0;
            evt_ovf    <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | set_press;
            pend_long  <= (pend_long  & ~clr_long)  | set_long;
            pend_rel   <= (pend_rel   & ~clr_rel)   | set_rel;
            if (gnt_valid) begin
                rr_ptr <= (int'(gnt_idx) == NB_BUTTONS - 1) ? '0 : gnt_idx + IW'(1);
            end
            if (ovf_hit) begin
                evt_ovf <= 1'b1;
            end else if (ovf_clr) begin
                evt_ovf <= 1'b0;
            end
        end
    end

    assign do_wr = gnt_valid;
    assign do_rd = evt_valid && evt_ready;

    // NOTE: FIFO storage has no reset; occupancy gates every read so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            fifo_mem[wr_ptr] <= {gnt_type, gnt_idx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign evt_valid = (fifo_cnt != '0);
    assign evt_data  = evt_valid ? fifo_mem[rd_ptr] : '0;

endmodule
